// File: rtl/ram_dump_reader_pkg.sv
// Shared types and default widths for the RAM dump reader.
// Build option RAM_DUMP_CHECKSUM_EN adds the CHK state (8-bit sum trailer beat).
package ram_dump_reader_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned CHK_W      = 8;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    SEND,
`ifdef RAM_DUMP_CHECKSUM_EN
    CHK,
`endif
    DONE
  } state_t;

endpackage : ram_dump_reader_pkg

// File: rtl/ram_dump_reader_if.sv
// Control, RAM read port and output stream of the dump reader in one bundle.
// master = the reader, slave = controller/RAM/sink side.
interface ram_dump_reader_if
  import ram_dump_reader_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] length;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_q;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    input  start, base_addr, length, mem_q, out_ready,
    output busy, done, mem_address, out_valid, out_data, out_last
  );

  modport slave (
    output start, base_addr, length, mem_q, out_ready,
    input  busy, done, mem_address, out_valid, out_data, out_last
  );

endinterface : ram_dump_reader_if

// File: rtl/dump_addr_counter.sv
// Read address and remaining-word counter for one dump.
// Address wraps modulo 2^ADDR_W; last flags the final word.
module dump_addr_counter #(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] len,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [ADDR_W-1:0] count;

  // load wins over inc; inc advances address and consumes one word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr  <= '0;
      count <= '0;
    end else if (load) begin
      addr  <= base;
      count <= len;
    end else if (inc) begin
      addr  <= addr + ADDR_W'(1);
      count <= count - ADDR_W'(1);
    end
  end

  assign last = (count == ADDR_W'(1));

endmodule : dump_addr_counter

// File: rtl/ram_dump_reader.sv
// Streams length words from a registered-output RAM starting at base_addr.
// Define RAM_DUMP_CHECKSUM_EN to append an 8-bit modular sum as the last beat.
module ram_dump_reader
  import ram_dump_reader_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  ram_dump_reader_if.master  bus
);

  state_t            state;
  state_t            state_nx;
  logic              load;
  logic              inc;
  logic              cnt_last;
  logic [ADDR_W-1:0] addr;
  logic              hs;

  logic              busy_nx;
  logic              valid_nx;
  logic              last_nx;
  logic [DATA_W-1:0] data_nx;

`ifdef RAM_DUMP_CHECKSUM_EN
  logic [CHK_W-1:0]  sum;
  logic [CHK_W-1:0]  sum_nx;
`endif

  // address register doubles as the RAM read address, so it only moves on entry to ISSUE
  dump_addr_counter #(.ADDR_W(ADDR_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .inc   (inc),
    .base  (bus.base_addr),
    .len   (bus.length),
    .addr  (addr),
    .last  (cnt_last)
  );

  assign bus.mem_address = addr;
  assign hs              = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    inc      = 1'b0;
    data_nx  = bus.out_data;
`ifdef RAM_DUMP_CHECKSUM_EN
    sum_nx   = sum;
`endif
    case (state)
      IDLE: begin
        if (bus.start) begin
`ifdef RAM_DUMP_CHECKSUM_EN
          sum_nx = '0;
`endif
          if (bus.length == '0) begin
            state_nx = DONE;
          end else begin
            load     = 1'b1;
            state_nx = ISSUE;
          end
        end
      end
      ISSUE: state_nx = WAIT;
      WAIT: begin
        data_nx  = bus.mem_q;
        state_nx = SEND;
      end
      SEND: begin
        if (hs) begin
`ifdef RAM_DUMP_CHECKSUM_EN
          sum_nx = sum + CHK_W'(bus.out_data);
`endif
          if (cnt_last) begin
`ifdef RAM_DUMP_CHECKSUM_EN
            data_nx  = DATA_W'(sum_nx);
            state_nx = CHK;
`else
            state_nx = DONE;
`endif
          end else begin
            inc      = 1'b1;
            state_nx = ISSUE;
          end
        end
      end
`ifdef RAM_DUMP_CHECKSUM_EN
      CHK: if (hs) state_nx = DONE;
`endif
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    busy_nx = (state_nx != IDLE);
`ifdef RAM_DUMP_CHECKSUM_EN
    valid_nx = (state_nx == SEND) || (state_nx == CHK);
    last_nx  = (state_nx == CHK);
`else
    valid_nx = (state_nx == SEND);
    last_nx  = (state_nx == SEND) && cnt_last;
`endif
  end

  // status/stream outputs track the next state; done trails the DONE state by one cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_data  <= '0;
    end else begin
      bus.busy      <= busy_nx;
      bus.done      <= (state == DONE);
      bus.out_valid <= valid_nx;
      bus.out_last  <= last_nx;
      bus.out_data  <= data_nx;
    end
  end

`ifdef RAM_DUMP_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sum <= '0;
    else        sum <= sum_nx;
  end
`endif

endmodule : ram_dump_reader
